// File: rtl/psg_pkg.sv
// psg_pkg: shared PSG register-file constants and the per-register write mask.
package psg_pkg;
    localparam int PSG_NUM_REGS  = 16;
    localparam int PSG_ADDR_BITS = 4;
    localparam int PSG_DATA_BITS = 8;
    localparam logic [PSG_ADDR_BITS-1:0] PSG_R_NOISE     = 4'd6;
    localparam logic [PSG_ADDR_BITS-1:0] PSG_R_MIXER     = 4'd7;
    localparam logic [PSG_ADDR_BITS-1:0] PSG_R_ENV_SHAPE = 4'd13;
    localparam logic [PSG_DATA_BITS-1:0] PSG_R7_RESET    = 8'h3F;

    // Unimplemented upper bits of each register always read back as zero.
    function automatic logic [PSG_DATA_BITS-1:0] psg_reg_mask(input logic [PSG_ADDR_BITS-1:0] addr);
        case (addr)
            4'd1, 4'd3, 4'd5, PSG_R_ENV_SHAPE: return 8'h0F;
            PSG_R_NOISE, 4'd8, 4'd9, 4'd10:    return 8'h1F;
            PSG_R_MIXER:                       return 8'h3F;
            default:                           return 8'hFF;
        endcase
    endfunction
endpackage

// File: rtl/psg_reg_write_scheduler_rr_arbiter.sv
// psg_rr_arbiter: NUM_REQ-way round-robin pick starting at ptr, one-hot grant.
module psg_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic               enable,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);
    always_comb begin
        grant = '0;
        // Walk from the farthest candidate back to ptr so the nearest valid one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--)
            grant = (enable && valid[(int'(ptr) + k) % NUM_REQ])
                  ? NUM_REQ'(1) << ((int'(ptr) + k) % NUM_REQ) : grant;
    end
endmodule

// File: rtl/psg_reg_write_scheduler.sv
// psg_reg_write_scheduler: arbitrates register writes and serialises them into
// address/data cycles for the PSG register file, keeping a shadow of all registers.
module psg_reg_write_scheduler
    import psg_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_BITS = PSG_ADDR_BITS,
    parameter int DATA_BITS = PSG_DATA_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_BITS-1:0]           bus_data,
    output logic                           bus_phase,
    output logic                           busy,
    input  logic [ADDR_BITS-1:0]           rd_addr,
    output logic [DATA_BITS-1:0]           rd_data
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    logic                 phase_q, phase_d, busy_q, busy_d, pend_q, pend_d, gnt_any;
    logic [ADDR_BITS-1:0] pend_addr_q, pend_addr_d, cur_addr_q, cur_addr_d, win_addr;
    logic [DATA_BITS-1:0] pend_data_q, pend_data_d, bus_data_q, bus_data_d, win_data, masked;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d, win;
    logic [NUM_REQ-1:0]   grant;
    logic [DATA_BITS-1:0] shadow_q [PSG_NUM_REGS];
    logic [DATA_BITS-1:0] shadow_d [PSG_NUM_REGS];

    // A pending write always drains in the phase-1 cycle after its grant,
    // so every phase-0 cycle is a free grant slot.
    psg_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .valid  (req_valid),
        .enable (~reset & ~phase_q & ~pend_q),
        .ptr    (rr_ptr_q),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign bus_data  = bus_data_q;
    assign bus_phase = phase_q;
    assign busy      = busy_q;
    assign rd_data   = shadow_q[rd_addr];
    assign gnt_any   = |grant;
    assign win_addr  = req_addr[int'(win)*ADDR_BITS +: ADDR_BITS];
    assign win_data  = req_data[int'(win)*DATA_BITS +: DATA_BITS];
    assign masked    = pend_data_q & DATA_BITS'(psg_reg_mask(pend_addr_q));

    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) win = PW'(i);
        phase_d     = ~phase_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        cur_addr_d  = cur_addr_q;
        rr_ptr_d    = rr_ptr_q;
        shadow_d    = shadow_q;
        busy_d      = gnt_any | pend_q | (busy_q & phase_q);
        if (!phase_q) begin
            bus_data_d = DATA_BITS'(gnt_any ? win_addr : cur_addr_q);
            if (gnt_any) begin
                pend_d      = 1'b1;
                pend_addr_d = win_addr;
                pend_data_d = win_data;
                cur_addr_d  = win_addr;
                rr_ptr_d    = PW'((int'(win) + 1) % NUM_REQ);
            end
        end else begin
            bus_data_d = pend_q ? masked : shadow_q[cur_addr_q];
            if (pend_q) shadow_d[pend_addr_q] = masked;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q     <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            cur_addr_q  <= '0;
            rr_ptr_q    <= '0;
            bus_data_q  <= '0;
            for (int i = 0; i < PSG_NUM_REGS; i++)
                shadow_q[i] <= (i == int'(PSG_R_MIXER)) ? DATA_BITS'(PSG_R7_RESET) : '0;
        end else begin
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            cur_addr_q  <= cur_addr_d;
            rr_ptr_q    <= rr_ptr_d;
            bus_data_q  <= bus_data_d;
            shadow_q    <= shadow_d;
        end
    end
endmodule

// File: tb/tb_psg_reg_write_scheduler.sv
// tb_psg_reg_write_scheduler: scoreboard bench; accepted writes are queued and
// matched against the address/data cycles that appear on the bus.
module tb_psg_reg_write_scheduler;
    localparam int N = 2;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } item_t;

    logic         clk = 0, reset = 1;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*4-1:0] req_addr = '0;
    logic [N*8-1:0] req_data = '0;
    logic [7:0]   bus_data, rd_data;
    logic         bus_phase, busy;
    logic [3:0]   rd_addr = '0;

    int    n_checks = 0, n_fail = 0;
    logic  exp_phase = 0;
    int    tb_ptr = 0;
    int    acc [N];
    item_t sb [$];
    item_t cur;
    bit    exp_dat_v = 0;

    psg_reg_write_scheduler #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .bus_data(bus_data),
        .bus_phase(bus_phase), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_mask(input logic [3:0] a);
        int w;
        w = (a inside {1, 3, 5, 13}) ? 4 : (a inside {6, 8, 9, 10}) ? 5 : (a == 7) ? 6 : 8;
        return 8'((1 << w) - 1);
    endfunction

    function automatic logic [N-1:0] ref_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] r = '0;
        bit found = 0;
        for (int k = 0; k < N; k++)
            if (!found && v[(p + k) % N]) begin
                found = 1;
                r[(p + k) % N] = 1'b1;
            end
        return r;
    endfunction

    always @(posedge clk) exp_phase <= reset ? 1'b0 : ~exp_phase;

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        if (reset) begin
            sb.delete();
            exp_dat_v = 0;
            tb_ptr = 0;
        end else begin
            check("phase", 32'(bus_phase), 32'(exp_phase));
            check("busy", 32'(busy), 32'(sb.size() != 0 || exp_dat_v));
            exp_rdy = exp_phase ? '0 : ref_pick(req_valid, tb_ptr);
            check("ready", 32'(req_ready), 32'(exp_rdy));
            for (int i = 0; i < N; i++)
                if (exp_rdy[i]) begin
                    sb.push_back('{a: req_addr[i*4 +: 4], d: req_data[i*8 +: 8] & ref_mask(req_addr[i*4 +: 4])});
                    tb_ptr = (i + 1) % N;
                    acc[i]++;
                end
            if (exp_dat_v) begin
                check("bus_wdata", 32'(bus_data), 32'(cur.d));
                exp_dat_v = 0;
            end
            if (bus_phase && busy) begin
                if (sb.size() == 0) check("sb_underflow", 32'(1), 32'(0));
                else begin
                    cur = sb.pop_front();
                    check("bus_waddr", 32'(bus_data), 32'(cur.a));
                    exp_dat_v = 1;
                end
            end
        end
    end

    task automatic align(input logic p);
        while (exp_phase != p) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_write(input int r, input logic [3:0] a, input logic [7:0] d, input int exp_wait);
        int w = 0;
        bit ok = 0;
        req_addr[r*4 +: 4] = a;
        req_data[r*8 +: 8] = d;
        req_valid[r] = 1'b1;
        while (!ok && w < 20) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1;
            else begin
                @(posedge clk); #1;
                w++;
            end
        end
        check("accept_wait", ok ? 32'(w) : 32'd99, 32'(exp_wait));
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic idle_check(input int n, input logic [7:0] a_val, input logic [7:0] d_val);
        repeat (n) begin
            @(negedge clk);
            check(bus_phase ? "idle_addr" : "idle_data", 32'(bus_data), 32'(bus_phase ? a_val : d_val));
        end
        @(posedge clk); #1;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int a0, a1, n;
        for (int i = 0; i < N; i++) acc[i] = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        // Idle after reset
        idle_check(8, 8'h00, 8'h00);
        rd_check("rst_r7", 4'd7, 8'h3F);
        rd_check("rst_r0", 4'd0, 8'h00);
        // Single write accepted in a phase-0 cycle
        align(0);
        do_write(0, 4'd1, 8'hAB, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_check("rd_r1", 4'd1, 8'h0B);
        // Request raised in a phase-1 cycle waits one cycle
        align(1);
        do_write(1, 4'd5, 8'h2C, 1);
        repeat (3) @(posedge clk);
        #1 rd_check("rd_r5", 4'd5, 8'h0C);
        // Two requesters contending continuously
        align(0);
        a0 = acc[0];
        a1 = acc[1];
        req_addr = {4'd3, 4'd2};
        req_data = {8'h05, 8'h11};
        req_valid = 2'b11;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            if (|req_ready) n++;
            if (n < 8) begin
                @(posedge clk); #1;
            end
        end
        check("contend_count", 32'(n), 32'd8);
        @(posedge clk); #1;
        req_valid = '0;
        check("starve_r0", 32'(acc[0] - a0), 32'd4);
        check("starve_r1", 32'(acc[1] - a1), 32'd4);
        repeat (3) @(posedge clk);
        #1 rd_check("rd_r2", 4'd2, 8'h11);
        rd_check("rd_r3", 4'd3, 8'h05);
        // Mixer write masked, then refresh rewrites it
        align(0);
        do_write(0, 4'd7, 8'hFF, 0);
        @(posedge clk); #1;
        idle_check(8, 8'h07, 8'h3F);
        rd_check("rd_r7", 4'd7, 8'h3F);
        // Reset in the cycle after an accept discards the write
        align(0);
        req_addr[3:0] = 4'd8;
        req_data[7:0] = 8'h1F;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("r8_accept", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset = 1;
        @(negedge clk);
        check("r8_addr", 32'(bus_data), 32'h08);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_bus", 32'(bus_data), 32'h00);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        check("post_rst_bus", 32'(bus_data), 32'h00);
        check("post_rst_busy", 32'(busy), 32'd0);
        rd_check("post_rst_r8", 4'd8, 8'h00);
        rd_check("post_rst_r7", 4'd7, 8'h3F);
        rd_check("post_rst_r1", 4'd1, 8'h00);
        @(posedge clk); #1;
        idle_check(6, 8'h00, 8'h00);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("sb_data_done", 32'(exp_dat_v), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
